// File: rtl/reg_file_sb.sv
// Parametrised register file with a destination-busy scoreboard: two combinational read ports,
// one clocked write port, register-0 and flat debug views. Optional write-through bypass: RF_BYPASS_EN.
module reg_file_sb #(
    parameter int  DW = 8,
    parameter int  PW = 3,
    localparam int N  = 2 ** PW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [PW-1:0]   wr_addr,
    input  logic [DW-1:0]   dat_in,
    input  logic [PW-1:0]   rd_addrA,
    input  logic [PW-1:0]   rd_addrB,
    input  logic            claim_en,
    input  logic [PW-1:0]   claim_addr,
    output logic [DW-1:0]   datA_out,
    output logic [DW-1:0]   datB_out,
    output logic [DW-1:0]   dat0_out,
    output logic            busyA,
    output logic            busyB,
    output logic [N-1:0]    busy_vec,
    output logic            claim_err,
    output logic [DW*N-1:0] regs_flat
);

    logic [DW-1:0] core [N];
    logic [N-1:0]  busy;
    logic [N-1:0]  busy_next;
    logic          wr_hits_claim;

    assign wr_hits_claim = wr_en && (wr_addr == claim_addr);

    // Claim is applied after the write clear so a same-address claim re-targets the register.
    always_comb begin
        busy_next = busy;
        if (wr_en)
            busy_next[wr_addr] = 1'b0;
        if (claim_en)
            busy_next[claim_addr] = 1'b1;
    end

    // NOTE: every core register is reset here because the debug view and read ports must show
    // zeros immediately on reset; a plain RAM without reset would not give that guarantee.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++)
                core[i] <= '0;
            busy      <= '0;
            claim_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop reading pre-edge values.
            if (wr_en)
                core[wr_addr] <= dat_in;
            busy      <= busy_next;
            claim_err <= claim_en && busy[claim_addr] && !wr_hits_claim;
        end
    end

    assign busy_vec = busy;

    always_comb begin
        for (int i = 0; i < N; i++)
            regs_flat[DW*i +: DW] = core[i];
    end

`ifdef RF_BYPASS_EN
    logic hit_a;
    logic hit_b;

    assign hit_a = wr_en && (wr_addr == rd_addrA);
    assign hit_b = wr_en && (wr_addr == rd_addrB);

    // NOTE: each output is fully assigned on every path, so no latch can be inferred.
    always_comb begin
        datA_out = hit_a ? dat_in : core[rd_addrA];
        datB_out = hit_b ? dat_in : core[rd_addrB];
        dat0_out = (wr_en && (wr_addr == '0)) ? dat_in : core[0];
        busyA    = busy[rd_addrA];
        busyB    = busy[rd_addrB];
        // A pending write frees the register now, unless a claim re-targets it this cycle.
        if (hit_a && !(claim_en && (claim_addr == rd_addrA)))
            busyA = 1'b0;
        if (hit_b && !(claim_en && (claim_addr == rd_addrB)))
            busyB = 1'b0;
    end
`else
    assign datA_out = core[rd_addrA];
    assign datB_out = core[rd_addrB];
    assign dat0_out = core[0];
    assign busyA    = busy[rd_addrA];
    assign busyB    = busy[rd_addrB];
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb (DW=8, PW=3): a driver updates an array-based reference
// model and queues the expected post-edge view; a monitor pops and compares after each edge.
module tb_reg_file_sb;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  dat_in;
    logic [2:0]  rd_addrA;
    logic [2:0]  rd_addrB;
    logic        claim_en;
    logic [2:0]  claim_addr;
    logic [7:0]  datA_out;
    logic [7:0]  datB_out;
    logic [7:0]  dat0_out;
    logic        busyA;
    logic        busyB;
    logic [7:0]  busy_vec;
    logic        claim_err;
    logic [63:0] regs_flat;

    reg_file_sb #(.DW(8), .PW(3)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
        .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .claim_en(claim_en), .claim_addr(claim_addr),
        .datA_out(datA_out), .datB_out(datB_out), .dat0_out(dat0_out), .busyA(busyA),
        .busyB(busyB), .busy_vec(busy_vec), .claim_err(claim_err), .regs_flat(regs_flat)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  z;
        logic        ba;
        logic        bb;
        logic [7:0]  bv;
        logic        cerr;
        logic [63:0] flat;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] mem_m [8];
    bit         busy_m [8];
    int         checks = 0;
    int         errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t view(input logic [2:0] ra, input logic [2:0] rb, input logic ce);
        exp_t e;
        e.a    = mem_m[ra];
        e.b    = mem_m[rb];
        e.z    = mem_m[0];
        e.ba   = busy_m[ra];
        e.bb   = busy_m[rb];
        e.cerr = ce;
        for (int i = 0; i < 8; i++) begin
            e.bv[i]         = busy_m[i];
            e.flat[8*i +: 8] = mem_m[i];
        end
        return e;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            mem_m[i]  = 8'h00;
            busy_m[i] = 1'b0;
        end
    endtask

    // One clock cycle of stimulus; the model state after the coming edge is queued.
    task automatic cycle(input bit we, input logic [2:0] wa, input logic [7:0] d,
                         input logic [2:0] ra, input logic [2:0] rb,
                         input bit ce, input logic [2:0] ca);
        bit cerr;
        @(negedge clk);
        reset = 1'b0;
        wr_en = we; wr_addr = wa; dat_in = d;
        rd_addrA = ra; rd_addrB = rb;
        claim_en = ce; claim_addr = ca;
        cerr = ce && busy_m[ca] && !(we && wa == ca);
        if (we) begin
            mem_m[wa]  = d;
            busy_m[wa] = 1'b0;
        end
        if (ce)
            busy_m[ca] = 1'b1;
        sb_q.push_back(view(ra, rb, cerr));
    endtask

    // Assert reset between edges with enables high; they must be ignored at the next edge.
    task automatic mid_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd3; dat_in = 8'hEE;
        claim_en = 1'b1; claim_addr = 3'd6;
        model_clear();
        #1;
        check("rst_regs_flat", regs_flat, 64'h0);
        check("rst_busy_vec", {56'h0, busy_vec}, 64'h0);
        check("rst_claim_err", {63'h0, claim_err}, 64'h0);
        check("rst_dat0", {56'h0, dat0_out}, 64'h0);
        sb_q.push_back(view(rd_addrA, rd_addrB, 1'b0));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("datA_out", {56'h0, datA_out}, {56'h0, e.a});
                check("datB_out", {56'h0, datB_out}, {56'h0, e.b});
                check("dat0_out", {56'h0, dat0_out}, {56'h0, e.z});
                check("busyA", {63'h0, busyA}, {63'h0, e.ba});
                check("busyB", {63'h0, busyB}, {63'h0, e.bb});
                check("busy_vec", {56'h0, busy_vec}, {56'h0, e.bv});
                check("claim_err", {63'h0, claim_err}, {63'h0, e.cerr});
                check("regs_flat", regs_flat, e.flat);
            end
        end
    end

    initial begin : driver
        wr_en = 1'b0; wr_addr = '0; dat_in = '0;
        rd_addrA = '0; rd_addrB = '0; claim_en = 1'b0; claim_addr = '0;
        reset = 1'b0;
        model_clear();
        #1 reset = 1'b1;
        #2;
        check("init_regs_flat", regs_flat, 64'h0);
        check("init_busy_vec", {56'h0, busy_vec}, 64'h0);
        check("init_claim_err", {63'h0, claim_err}, 64'h0);

        // Reset mid-run with a live claim_err pulse and busy bit.
        cycle(1, 3'd3, 8'hA5, 3'd3, 3'd5, 0, 3'd0);
        cycle(0, 3'd0, 8'h00, 3'd3, 3'd5, 1, 3'd5);
        cycle(0, 3'd0, 8'h00, 3'd3, 3'd5, 1, 3'd5);
        mid_reset();
        cycle(0, 3'd0, 8'h00, 3'd3, 3'd5, 0, 3'd0);

        // Write/read, scoreboard life cycle, simultaneous claim+write.
        cycle(1, 3'd6, 8'h3C, 3'd6, 3'd0, 0, 3'd0);
        cycle(0, 3'd0, 8'h00, 3'd2, 3'd6, 1, 3'd2);
        cycle(1, 3'd2, 8'h11, 3'd2, 3'd6, 0, 3'd0);
        cycle(1, 3'd4, 8'h77, 3'd4, 3'd2, 1, 3'd4);

        // Double claim, then double claim with a write in the second cycle.
        cycle(0, 3'd0, 8'h00, 3'd1, 3'd4, 1, 3'd1);
        cycle(0, 3'd0, 8'h00, 3'd1, 3'd4, 1, 3'd1);
        cycle(0, 3'd0, 8'h00, 3'd1, 3'd4, 0, 3'd0);
        cycle(1, 3'd1, 8'h5A, 3'd1, 3'd4, 0, 3'd0);
        cycle(0, 3'd0, 8'h00, 3'd1, 3'd4, 1, 3'd1);
        cycle(1, 3'd1, 8'h66, 3'd1, 3'd4, 1, 3'd1);

        // Independent ports: claim r7 while writing r0.
        cycle(1, 3'd4, 8'h00, 3'd0, 3'd0, 0, 3'd0);
        cycle(1, 3'd1, 8'h00, 3'd0, 3'd0, 0, 3'd0);
        cycle(1, 3'd0, 8'hFF, 3'd0, 3'd0, 1, 3'd7);

        for (int n = 0; n < 400; n++) begin
            if (n == 200)
                mid_reset();
            cycle($urandom_range(0, 1), 3'($urandom_range(0, 7)), 8'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 1), 3'($urandom_range(0, 7)));
        end

        @(negedge clk);
        wr_en = 1'b0; claim_en = 1'b0;
        @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
